// File: rtl/opb_slave_frontend.sv
// OPB slave front end: window decode, one-shot decoder strobes, read capture, xferAck.
// Define OPB_SLV_TOUTSUP_EN to drive Sl_toutSup during read strobe/wait cycles.
module opb_slave_frontend #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] WIN_SIZE  = 32'h0001_0000,
  parameter int unsigned RD_WAIT   = 0
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        OPB_select,
  input  logic        OPB_RNW,
  input  logic [31:0] OPB_ABus,
  input  logic [31:0] OPB_DBus,
  output logic        Sl_xferAck,
  output logic [31:0] Sl_DBus,
  output logic        Sl_toutSup,
  output logic        DEC_RE,
  output logic        DEC_WE,
  output logic [31:0] DEC_ADDR,
  output logic [31:0] DEC_DI,
  input  logic [31:0] DEC_DO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_STB,
    S_RD_WAIT,
    S_ACK,
    S_DONE
  } state_t;

  localparam logic [3:0]  LP_WAIT = 4'(RD_WAIT);
  localparam logic [32:0] LP_LO   = {1'b0, BASE_ADDR};
  localparam logic [32:0] LP_HI   = {1'b0, BASE_ADDR} + {1'b0, WIN_SIZE};

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_ack;
  logic        r_re;
  logic        r_we;
  logic [31:0] r_dbus;
  logic [31:0] r_addr;
  logic [31:0] r_di;
  logic        w_hit;
  logic        w_start;
  logic        w_cap;

  assign w_hit   = ({1'b0, OPB_ABus} >= LP_LO) &&
                   ({1'b0, OPB_ABus} <  LP_HI);
  assign w_start = (r_state == S_IDLE) && OPB_select && w_hit;
  assign w_cap   = (r_state == S_RD_WAIT) && (w_next == S_ACK);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start)
          w_next = OPB_RNW ? S_RD_STB : S_ACK;
      end
      S_RD_STB: begin
        w_next = OPB_select ? S_RD_WAIT : S_IDLE;
      end
      S_RD_WAIT: begin
        if (!OPB_select)
          w_next = S_IDLE;
        else if (r_cnt == 4'd0)
          w_next = S_ACK;
      end
      S_ACK:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RD_STB)
        r_cnt <= LP_WAIT;
      else if (r_state == S_RD_WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      r_ack  <= 1'b0;
      r_re   <= 1'b0;
      r_we   <= 1'b0;
      r_dbus <= 32'd0;
      r_addr <= 32'd0;
      r_di   <= 32'd0;
    end else begin
      r_ack  <= (w_next == S_ACK);
      r_re   <= w_start && OPB_RNW;
      r_we   <= w_start && !OPB_RNW;
      r_dbus <= w_cap ? DEC_DO : 32'd0;
      if (w_start) begin
        r_addr <= OPB_ABus;
        r_di   <= OPB_DBus;
      end
    end
  end

`ifdef OPB_SLV_TOUTSUP_EN
  logic r_tos;

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST)
      r_tos <= 1'b0;
    else
      r_tos <= (w_next == S_RD_STB) || (w_next == S_RD_WAIT);
  end

  assign Sl_toutSup = r_tos;
`else
  assign Sl_toutSup = 1'b0;
`endif

  assign Sl_xferAck = r_ack;
  assign Sl_DBus    = r_dbus;
  assign DEC_RE     = r_re;
  assign DEC_WE     = r_we;
  assign DEC_ADDR   = r_addr;
  assign DEC_DI     = r_di;

endmodule

// File: tb/tb_opb_slave_frontend.sv
// Directed bench for opb_slave_frontend: three instances (RD_WAIT 0, 4, 15)
// share one OPB stimulus stream; each phase checks the relevant instance.
module tb_opb_slave_frontend;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        rnw;
  logic [31:0] abus;
  logic [31:0] dbus;
  logic [31:0] ddo;

  logic        ack_0, tos_0, re_0, we_0;
  logic [31:0] sdb_0, adr_0, di_0;
  logic        ack_4, tos_4, re_4, we_4;
  logic [31:0] sdb_4, adr_4, di_4;
  logic        ack_15, tos_15, re_15, we_15;
  logic [31:0] sdb_15, adr_15, di_15;

  int n_err;
  int n_chk;

  logic [31:0] m_re, m_we, m_ack, m_tos, exp_tos;
  int          cnt;

  opb_slave_frontend #(.RD_WAIT(0)) u0 (
    .OPB_CLK(clk), .OPB_RST(rst), .OPB_select(sel), .OPB_RNW(rnw),
    .OPB_ABus(abus), .OPB_DBus(dbus),
    .Sl_xferAck(ack_0), .Sl_DBus(sdb_0), .Sl_toutSup(tos_0),
    .DEC_RE(re_0), .DEC_WE(we_0), .DEC_ADDR(adr_0), .DEC_DI(di_0),
    .DEC_DO(ddo)
  );

  opb_slave_frontend #(.RD_WAIT(4)) u4 (
    .OPB_CLK(clk), .OPB_RST(rst), .OPB_select(sel), .OPB_RNW(rnw),
    .OPB_ABus(abus), .OPB_DBus(dbus),
    .Sl_xferAck(ack_4), .Sl_DBus(sdb_4), .Sl_toutSup(tos_4),
    .DEC_RE(re_4), .DEC_WE(we_4), .DEC_ADDR(adr_4), .DEC_DI(di_4),
    .DEC_DO(ddo)
  );

  opb_slave_frontend #(.RD_WAIT(15)) u15 (
    .OPB_CLK(clk), .OPB_RST(rst), .OPB_select(sel), .OPB_RNW(rnw),
    .OPB_ABus(abus), .OPB_DBus(dbus),
    .Sl_xferAck(ack_15), .Sl_DBus(sdb_15), .Sl_toutSup(tos_15),
    .DEC_RE(re_15), .DEC_WE(we_15), .DEC_ADDR(adr_15), .DEC_DI(di_15),
    .DEC_DO(ddo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    sel = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    rst   = 1'b1;
    sel   = 1'b0;
    rnw   = 1'b0;
    abus  = 32'd0;
    dbus  = 32'd0;
    ddo   = 32'hAAAA_5555;
`ifdef OPB_SLV_TOUTSUP_EN
    exp_tos = 32'h0003_FFFE;
`else
    exp_tos = 32'd0;
`endif

    // reset state
    tick();
    tick();
    chk("rst_ack", 32'(ack_0), 32'd0);
    chk("rst_dbus", sdb_0, 32'd0);
    chk("rst_tos", 32'(tos_0), 32'd0);
    chk("rst_re", 32'(re_0), 32'd0);
    chk("rst_we", 32'(we_0), 32'd0);
    chk("rst_addr", adr_0, 32'd0);
    chk("rst_di", di_0, 32'd0);
    rst = 1'b0;
    idle(3);

    // write hit
    sel = 1'b1; rnw = 1'b0; abus = 32'h8000_0010; dbus = 32'hDEAD_BEEF;
    tick();
    chk("wr_we", 32'(we_0), 32'd1);
    chk("wr_re", 32'(re_0), 32'd0);
    chk("wr_ack", 32'(ack_0), 32'd1);
    chk("wr_addr", adr_0, 32'h8000_0010);
    chk("wr_di", di_0, 32'hDEAD_BEEF);
    chk("wr_dbus", sdb_0, 32'd0);
    chk("wr_tos", 32'(tos_0), 32'd0);
    sel = 1'b0; abus = 32'd0; dbus = 32'd0;
    tick();
    chk("wr_we_off", 32'(we_0), 32'd0);
    chk("wr_ack_off", 32'(ack_0), 32'd0);
    chk("wr_addr_hold", adr_0, 32'h8000_0010);
    chk("wr_di_hold", di_0, 32'hDEAD_BEEF);
    idle(25);

    // read hit, RD_WAIT=0
    sel = 1'b1; rnw = 1'b1; abus = 32'h8000_0020;
    tick();
    chk("rd_re_t1", 32'(re_0), 32'd1);
    chk("rd_ack_t1", 32'(ack_0), 32'd0);
    chk("rd_dbus_t1", sdb_0, 32'd0);
    tick();
    chk("rd_re_t2", 32'(re_0), 32'd0);
    chk("rd_dbus_t2", sdb_0, 32'd0);
    ddo = 32'h1234_5678;
    tick();
    chk("rd_ack_t3", 32'(ack_0), 32'd1);
    chk("rd_dbus_t3", sdb_0, 32'h1234_5678);
    chk("rd_addr", adr_0, 32'h8000_0020);
    sel = 1'b0; ddo = 32'hAAAA_5555;
    tick();
    chk("rd_ack_t4", 32'(ack_0), 32'd0);
    chk("rd_dbus_t4", sdb_0, 32'd0);
    idle(25);

    // window misses on both sides
    cnt = 0;
    sel = 1'b1; rnw = 1'b0; abus = 32'h8001_0000;
    for (int k = 1; k <= 20; k++) begin
      tick();
      cnt += int'(re_0) + int'(we_0) + int'(ack_0);
      if (k == 10) begin
        rnw = 1'b1; abus = 32'h7FFF_FFFC;
      end
    end
    chk("miss_events", 32'(cnt), 32'd0);
    idle(2);

    // top-of-window hit
    sel = 1'b1; rnw = 1'b0; abus = 32'h8000_FFFC; dbus = 32'h0000_00A5;
    tick();
    chk("edge_ack", 32'(ack_0), 32'd1);
    chk("edge_addr", adr_0, 32'h8000_FFFC);
    idle(25);

    // write with select held
    m_we = 0; m_re = 0; m_ack = 0;
    sel = 1'b1; rnw = 1'b0; abus = 32'h8000_0040; dbus = 32'h1111_2222;
    for (int k = 1; k <= 9; k++) begin
      tick();
      m_we[k] = we_0; m_re[k] = re_0; m_ack[k] = ack_0;
      if (k == 8) sel = 1'b0;
    end
    chk("hold_wr_we", m_we, 32'h0000_0092);
    chk("hold_wr_ack", m_ack, 32'h0000_0092);
    chk("hold_wr_re", m_re, 32'd0);
    idle(25);

    // read with select held
    m_we = 0; m_re = 0; m_ack = 0;
    sel = 1'b1; rnw = 1'b1; abus = 32'h8000_0060;
    for (int k = 1; k <= 12; k++) begin
      tick();
      m_we[k] = we_0; m_re[k] = re_0; m_ack[k] = ack_0;
      if (k == 12) sel = 1'b0;
    end
    chk("hold_rd_re", m_re, 32'h0000_0842);
    chk("hold_rd_ack", m_ack, 32'h0000_0108);
    chk("hold_rd_we", m_we, 32'd0);
    idle(25);

    // abort at T+2 with RD_WAIT=4, then a write accepted at T+3
    m_we = 0; m_re = 0; m_ack = 0;
    sel = 1'b1; rnw = 1'b1; abus = 32'h8000_0030;
    for (int k = 1; k <= 5; k++) begin
      tick();
      m_we[k] = we_4; m_re[k] = re_4; m_ack[k] = ack_4;
      if (k == 2) sel = 1'b0;
      if (k == 3) begin
        sel = 1'b1; rnw = 1'b0; abus = 32'h8000_0034; dbus = 32'h5A5A_5A5A;
      end
      if (k == 4) sel = 1'b0;
    end
    chk("abort_re", m_re, 32'h0000_0002);
    chk("abort_ack", m_ack, 32'h0000_0010);
    chk("abort_we", m_we, 32'h0000_0010);
    chk("abort_addr", adr_4, 32'h8000_0034);
    idle(25);

    // RD_WAIT=15 read, timeout suppress window
    m_re = 0; m_ack = 0; m_tos = 0;
    ddo = 32'hCAFE_F00D;
    sel = 1'b1; rnw = 1'b1; abus = 32'h8000_0050;
    for (int k = 1; k <= 20; k++) begin
      tick();
      m_re[k] = re_15; m_ack[k] = ack_15; m_tos[k] = tos_15;
      if (k == 18) chk("w15_dbus", sdb_15, 32'hCAFE_F00D);
      if (k == 18) sel = 1'b0;
    end
    chk("w15_re", m_re, 32'h0000_0002);
    chk("w15_ack", m_ack, 32'h0004_0000);
    chk("w15_tos", m_tos, exp_tos);
    idle(25);

    // same read, reset asserted at T+5
    sel = 1'b1; rnw = 1'b1; abus = 32'h8000_0070; dbus = 32'h7777_8888;
    for (int k = 1; k <= 5; k++) tick();
    chk("rst15_tos_pre", 32'(tos_15), 32'(exp_tos[5]));
    rst = 1'b1;
    tick();
    chk("rst15_ack", 32'(ack_15), 32'd0);
    chk("rst15_dbus", sdb_15, 32'd0);
    chk("rst15_tos", 32'(tos_15), 32'd0);
    chk("rst15_re", 32'(re_15), 32'd0);
    chk("rst15_we", 32'(we_15), 32'd0);
    chk("rst15_addr", adr_15, 32'd0);
    chk("rst15_di", di_15, 32'd0);
    rst = 1'b0; sel = 1'b0;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      cnt += int'(ack_15) + int'(re_15);
    end
    chk("rst15_quiet", 32'(cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
